dispatch_buffer: RTL and testbench

- Two-wide in-order FIFO between the rename stage and the issue queues.
- Captures up to 2 renamed micro-ops per cycle and tags each source operand ready/not-ready from the busy-bit table.
- Keeps those ready tags current from writeback wakeups while entries wait.
- Hands micro-ops to the issue queues oldest-first, up to 2 per cycle. Back-pressures rename when full; empties completely on flush or branch recall.

---
 rtl/dispatch_buffer.sv | 164 ++++++++++++++++
 tb/tb_dispatch_buffer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_buffer.sv
// Two-wide in-order dispatch buffer between rename and the issue queues.
// Source operands carry ready tags that are set from the busy-bit table and refreshed by writeback wakeups.
module dispatch_buffer #(
    parameter int DEPTH     = 8,
    parameter int PAYLOAD_W = 128,
    parameter int AL_W      = 5,
    parameter int CP_W      = 2,
    parameter int NUM_WB    = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ext_flush,
    input  logic                   if_recall,
    input  logic [1:0]             in_valid,
    input  logic [1:0]             in_uses_rs1,
    input  logic [1:0]             in_uses_rs2,
    input  logic [1:0]             in_uses_rd,
    input  logic [11:0]            in_rs1,
    input  logic [11:0]            in_rs2,
    input  logic [11:0]            in_rd,
    input  logic [2*AL_W-1:0]      in_al_addr,
    input  logic [2*CP_W-1:0]      in_cp_addr,
    input  logic [2*PAYLOAD_W-1:0] in_payload,
    input  logic [63:0]            bbt,
    input  logic [NUM_WB-1:0]      wb_valid,
    input  logic [NUM_WB*6-1:0]    wb_rd,
    output logic                   in_stall,
    output logic [1:0]             out_valid,
    output logic [1:0]             out_uses_rs1,
    output logic [1:0]             out_uses_rs2,
    output logic [1:0]             out_uses_rd,
    output logic [11:0]            out_rs1,
    output logic [11:0]            out_rs2,
    output logic [11:0]            out_rd,
    output logic [2*AL_W-1:0]      out_al_addr,
    output logic [2*CP_W-1:0]      out_cp_addr,
    output logic [2*PAYLOAD_W-1:0] out_payload,
    output logic [1:0]             out_rs1_ready,
    output logic [1:0]             out_rs2_ready,
    input  logic [1:0]             iq_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head, tail, wr1_idx;
    logic [PTR_W-1:0] rd_idx [2];
    logic [CNT_W-1:0] count, enq_n, deq_n;
    logic             flush, enq_ok, wr0_en, wr1_en, deq0, deq1;
    logic [1:0]       rdy1_in, rdy2_in;

    logic [DEPTH-1:0] ent_valid, ent_rdy1, ent_rdy2;
    logic [5:0]           ent_rs1 [DEPTH];
    logic [5:0]           ent_rs2 [DEPTH];
    logic [5:0]           ent_rd  [DEPTH];
    logic [DEPTH-1:0]     ent_u1, ent_u2, ent_ud;
    logic [AL_W-1:0]      ent_al  [DEPTH];
    logic [CP_W-1:0]      ent_cp  [DEPTH];
    logic [PAYLOAD_W-1:0] ent_pl  [DEPTH];

    function automatic logic wb_hit(input logic [5:0] preg, input logic [NUM_WB-1:0] v,
                                    input logic [NUM_WB*6-1:0] r);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_WB; k++)
            if (v[k] && r[k*6 +: 6] == preg) hit = 1'b1;
        return hit;
    endfunction

    assign flush     = ext_flush | if_recall;
    assign in_stall  = (CNT_W'(DEPTH) - count) < CNT_W'(2);
    assign rd_idx[0] = head;
    assign rd_idx[1] = head + PTR_W'(1);

    for (genvar i = 0; i < 2; i++) begin : g_out
        assign out_valid[i]                    = ent_valid[rd_idx[i]];
        assign out_uses_rs1[i]                 = ent_u1[rd_idx[i]];
        assign out_uses_rs2[i]                 = ent_u2[rd_idx[i]];
        assign out_uses_rd[i]                  = ent_ud[rd_idx[i]];
        assign out_rs1[i*6 +: 6]               = ent_rs1[rd_idx[i]];
        assign out_rs2[i*6 +: 6]               = ent_rs2[rd_idx[i]];
        assign out_rd[i*6 +: 6]                = ent_rd[rd_idx[i]];
        assign out_al_addr[i*AL_W +: AL_W]     = ent_al[rd_idx[i]];
        assign out_cp_addr[i*CP_W +: CP_W]     = ent_cp[rd_idx[i]];
        assign out_payload[i*PAYLOAD_W +: PAYLOAD_W] = ent_pl[rd_idx[i]];
        // A same-cycle wakeup lets the op issue in the cycle its source is written back.
        assign out_rs1_ready[i] = ent_rdy1[rd_idx[i]] | wb_hit(ent_rs1[rd_idx[i]], wb_valid, wb_rd);
        assign out_rs2_ready[i] = ent_rdy2[rd_idx[i]] | wb_hit(ent_rs2[rd_idx[i]], wb_valid, wb_rd);
    end

    // NOTE: always_comb assigns every output a default first, so no path can leave a latch.
    always_comb begin
        rdy1_in = '0;
        rdy2_in = '0;
        for (int s = 0; s < 2; s++) begin
            rdy1_in[s] = ~in_uses_rs1[s] | ~bbt[in_rs1[s*6 +: 6]] | wb_hit(in_rs1[s*6 +: 6], wb_valid, wb_rd);
            rdy2_in[s] = ~in_uses_rs2[s] | ~bbt[in_rs2[s*6 +: 6]] | wb_hit(in_rs2[s*6 +: 6], wb_valid, wb_rd);
        end
    end

    // Valid slots are compacted: a lone slot-1 op lands at tail.
    assign enq_ok  = ~in_stall & ~flush;
    assign wr0_en  = enq_ok & in_valid[0];
    assign wr1_en  = enq_ok & in_valid[1];
    assign wr1_idx = tail + PTR_W'(in_valid[0]);
    assign enq_n   = CNT_W'(wr0_en) + CNT_W'(wr1_en);

    assign deq0  = out_valid[0] & iq_ready[0] & ~flush;
    assign deq1  = deq0 & out_valid[1] & iq_ready[1];
    assign deq_n = CNT_W'(deq0) + CNT_W'(deq1);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_valid <= '0;
        end else begin
            if (deq0) ent_valid[head]      <= 1'b0;
            if (deq1) ent_valid[rd_idx[1]] <= 1'b0;
            if (wr0_en) ent_valid[tail]    <= 1'b1;
            if (wr1_en) ent_valid[wr1_idx] <= 1'b1;
            head  <= head + PTR_W'(deq0) + PTR_W'(deq1);
            tail  <= tail + PTR_W'(wr0_en) + PTR_W'(wr1_en);
            count <= count + enq_n - deq_n;
        end
    end

    // NOTE: entry contents and ready tags are not reset; they are only observed behind a valid bit.
    always_ff @(posedge clk) begin
        for (int e = 0; e < DEPTH; e++) begin
            if (ent_valid[e] && wb_hit(ent_rs1[e], wb_valid, wb_rd)) ent_rdy1[e] <= 1'b1;
            if (ent_valid[e] && wb_hit(ent_rs2[e], wb_valid, wb_rd)) ent_rdy2[e] <= 1'b1;
        end
        if (wr0_en) begin
            ent_rs1[tail]  <= in_rs1[5:0];
            ent_rs2[tail]  <= in_rs2[5:0];
            ent_rd[tail]   <= in_rd[5:0];
            ent_u1[tail]   <= in_uses_rs1[0];
            ent_u2[tail]   <= in_uses_rs2[0];
            ent_ud[tail]   <= in_uses_rd[0];
            ent_al[tail]   <= in_al_addr[AL_W-1:0];
            ent_cp[tail]   <= in_cp_addr[CP_W-1:0];
            ent_pl[tail]   <= in_payload[PAYLOAD_W-1:0];
            ent_rdy1[tail] <= rdy1_in[0];
            ent_rdy2[tail] <= rdy2_in[0];
        end
        if (wr1_en) begin
            ent_rs1[wr1_idx]  <= in_rs1[11:6];
            ent_rs2[wr1_idx]  <= in_rs2[11:6];
            ent_rd[wr1_idx]   <= in_rd[11:6];
            ent_u1[wr1_idx]   <= in_uses_rs1[1];
            ent_u2[wr1_idx]   <= in_uses_rs2[1];
            ent_ud[wr1_idx]   <= in_uses_rd[1];
            ent_al[wr1_idx]   <= in_al_addr[2*AL_W-1:AL_W];
            ent_cp[wr1_idx]   <= in_cp_addr[2*CP_W-1:CP_W];
            ent_pl[wr1_idx]   <= in_payload[2*PAYLOAD_W-1:PAYLOAD_W];
            ent_rdy1[wr1_idx] <= rdy1_in[1];
            ent_rdy2[wr1_idx] <= rdy2_in[1];
        end
    end

endmodule

// File: tb/tb_dispatch_buffer.sv
// Scoreboard bench for dispatch_buffer: stimulus pushes expected ops, a negedge monitor pops on every handoff.
// Ready tags, stall and head contents are checked directly against hand-computed values.
module tb_dispatch_buffer;

    localparam int DEPTH = 8;
    localparam int PW    = 128;
    localparam int AW    = 5;
    localparam int CW    = 2;
    localparam int NWB   = 2;

    logic            clk = 1'b0;
    logic            reset, ext_flush, if_recall;
    logic [1:0]      in_valid, in_uses_rs1, in_uses_rs2, in_uses_rd;
    logic [11:0]     in_rs1, in_rs2, in_rd;
    logic [2*AW-1:0] in_al_addr;
    logic [2*CW-1:0] in_cp_addr;
    logic [2*PW-1:0] in_payload;
    logic [63:0]     bbt;
    logic [NWB-1:0]  wb_valid;
    logic [NWB*6-1:0] wb_rd;
    logic            in_stall;
    logic [1:0]      out_valid, out_uses_rs1, out_uses_rs2, out_uses_rd;
    logic [11:0]     out_rs1, out_rs2, out_rd;
    logic [2*AW-1:0] out_al_addr;
    logic [2*CW-1:0] out_cp_addr;
    logic [2*PW-1:0] out_payload;
    logic [1:0]      out_rs1_ready, out_rs2_ready, iq_ready;

    dispatch_buffer #(.DEPTH(DEPTH), .PAYLOAD_W(PW), .AL_W(AW), .CP_W(CW), .NUM_WB(NWB)) dut (
        .clk(clk), .reset(reset), .ext_flush(ext_flush), .if_recall(if_recall),
        .in_valid(in_valid), .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2),
        .in_uses_rd(in_uses_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_al_addr(in_al_addr), .in_cp_addr(in_cp_addr), .in_payload(in_payload),
        .bbt(bbt), .wb_valid(wb_valid), .wb_rd(wb_rd), .in_stall(in_stall),
        .out_valid(out_valid), .out_uses_rs1(out_uses_rs1), .out_uses_rs2(out_uses_rs2),
        .out_uses_rd(out_uses_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_al_addr(out_al_addr), .out_cp_addr(out_cp_addr), .out_payload(out_payload),
        .out_rs1_ready(out_rs1_ready), .out_rs2_ready(out_rs2_ready), .iq_ready(iq_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]    rs1, rs2, rd;
        logic          u1, u2, ud;
        logic [AW-1:0] al;
        logic [CW-1:0] cp;
        logic [PW-1:0] pl;
    } op_t;

    op_t sb[$];
    int  checks   = 0;
    int  failures = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic op_t mk(input int tag);
        op_t o;
        logic [31:0] t;
        t     = tag;
        o.rs1 = t[5:0];
        o.rs2 = 6'(t + 1);
        o.rd  = 6'(t + 2);
        o.u1  = t[0];
        o.u2  = 1'b1;
        o.ud  = ~t[1];
        o.al  = t[AW-1:0];
        o.cp  = t[CW-1:0];
        o.pl  = {t, ~t, t << 4, 32'hA5A5_0000 | t};
        return o;
    endfunction

    function automatic op_t out_op(input int i);
        op_t o;
        o.rs1 = out_rs1[i*6 +: 6];
        o.rs2 = out_rs2[i*6 +: 6];
        o.rd  = out_rd[i*6 +: 6];
        o.u1  = out_uses_rs1[i];
        o.u2  = out_uses_rs2[i];
        o.ud  = out_uses_rd[i];
        o.al  = out_al_addr[i*AW +: AW];
        o.cp  = out_cp_addr[i*CW +: CW];
        o.pl  = out_payload[i*PW +: PW];
        return o;
    endfunction

    task automatic drive(input int s, input op_t o);
        in_rs1[s*6 +: 6]       = o.rs1;
        in_rs2[s*6 +: 6]       = o.rs2;
        in_rd[s*6 +: 6]        = o.rd;
        in_uses_rs1[s]         = o.u1;
        in_uses_rs2[s]         = o.u2;
        in_uses_rd[s]          = o.ud;
        in_al_addr[s*AW +: AW] = o.al;
        in_cp_addr[s*CW +: CW] = o.cp;
        in_payload[s*PW +: PW] = o.pl;
    endtask

    task automatic present(input logic [1:0] v, input op_t a, input op_t b, input bit accept);
        in_valid = v;
        drive(0, a);
        drive(1, b);
        if (accept) begin
            if (v[0]) sb.push_back(a);
            if (v[1]) sb.push_back(b);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [1:0] v, input op_t a, input op_t b, input bit accept);
        present(v, a, b, accept);
        step();
        in_valid = 2'b00;
    endtask

    task automatic drain(input int cycles);
        iq_ready = 2'b11;
        repeat (cycles) step();
        iq_ready = 2'b00;
    endtask

    // Monitor: every handoff the DUT offers and the issue queues accept is compared in order.
    always @(negedge clk) begin
        if (!reset && !ext_flush && !if_recall) begin
            bit go0, go1;
            go0 = out_valid[0] & iq_ready[0];
            go1 = go0 & out_valid[1] & iq_ready[1];
            for (int i = 0; i < 2; i++) begin
                if ((i == 0) ? go0 : go1) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_unexpected slot=%0d actual_pl=%0h expected=none", i, out_payload[i*PW +: PW]);
                    end else begin
                        check("sb_op", out_op(i), sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        op_t a, b;
        reset = 1'b1; ext_flush = 1'b0; if_recall = 1'b0;
        in_valid = '0; in_uses_rs1 = '0; in_uses_rs2 = '0; in_uses_rd = '0;
        in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_al_addr = '0; in_cp_addr = '0; in_payload = '0;
        bbt = '0; wb_valid = '0; wb_rd = '0; iq_ready = '0;
        step();
        check("rst_out_valid", out_valid, 2'b00);
        check("rst_in_stall", in_stall, 1'b0);
        step();
        reset = 1'b0;

        // Fill to DEPTH, stall, then hold an extra pair that must be dropped.
        enq(2'b11, mk(1), mk(2), 1); check("fill2_stall", in_stall, 1'b0);
        enq(2'b11, mk(3), mk(4), 1); check("fill4_stall", in_stall, 1'b0);
        enq(2'b11, mk(5), mk(6), 1); check("fill6_stall", in_stall, 1'b0);
        enq(2'b11, mk(7), mk(8), 1); check("fill8_stall", in_stall, 1'b1);
        present(2'b11, mk(9), mk(10), 0);
        for (int c = 0; c < 3; c++) begin
            step();
            check("held_stall", in_stall, 1'b1);
        end
        in_valid = 2'b00;
        check("full_head_pl", out_payload[PW-1:0], mk(1).pl);
        check("full_out_valid", out_valid, 2'b11);

        // Drain from full, then position head/tail at 6 and fill across the wrap.
        drain(4);
        check("drained_valid", out_valid, 2'b00);
        check("drained_stall", in_stall, 1'b0);
        enq(2'b11, mk(11), mk(12), 1);
        enq(2'b11, mk(13), mk(14), 1);
        enq(2'b11, mk(15), mk(16), 1);
        drain(3);
        check("at6_valid", out_valid, 2'b00);
        enq(2'b11, mk(21), mk(22), 1);
        enq(2'b11, mk(23), mk(24), 1);
        enq(2'b11, mk(25), mk(26), 1);
        check("wrap_h6_slot0", out_payload[PW-1:0], mk(21).pl);
        check("wrap_h6_slot1", out_payload[2*PW-1:PW], mk(22).pl);
        iq_ready = 2'b01;
        step();
        iq_ready = 2'b00;
        check("wrap_h7_slot0", out_payload[PW-1:0], mk(22).pl);
        check("wrap_h7_slot1", out_payload[2*PW-1:PW], mk(23).pl);
        drain(3);
        check("wrap_empty", out_valid, 2'b00);

        // Ready tagging from the busy table and wakeup.
        a = mk(30); a.rs1 = 6'd17; a.u1 = 1'b1;
        b = mk(31); b.rs1 = 6'd17; b.u1 = 1'b0;
        bbt[17] = 1'b1;
        enq(2'b11, a, b, 1);
        check("rdy_busy", out_rs1_ready, 2'b10);
        wb_valid = 2'b01; wb_rd = {6'd0, 6'd17};
        #1;
        check("rdy_same_cycle_wb", out_rs1_ready, 2'b11);
        step();
        wb_valid = 2'b00;
        #1;
        check("rdy_stored_wb", out_rs1_ready, 2'b11);
        bbt = '0;
        drain(1);

        // Wakeup on the enqueue cycle itself.
        a = mk(32); a.rs2 = 6'd40; a.u2 = 1'b1;
        b = mk(33); b.rs2 = 6'd41; b.u2 = 1'b1;
        bbt[40] = 1'b1; bbt[41] = 1'b1;
        wb_valid = 2'b10; wb_rd = {6'd40, 6'd0};
        enq(2'b11, a, b, 1);
        wb_valid = 2'b00;
        #1;
        check("enq_wakeup_rs2", out_rs2_ready, 2'b01);
        bbt = '0;
        drain(1);

        // Partial dispatch and lone slot-1 enqueue.
        enq(2'b11, mk(40), mk(41), 1);
        iq_ready = 2'b10;
        step();
        check("part_n0_valid", out_valid, 2'b11);
        check("part_n0_head", out_payload[PW-1:0], mk(40).pl);
        iq_ready = 2'b01;
        step();
        iq_ready = 2'b00;
        check("part_n1_valid", out_valid, 2'b01);
        check("part_n1_head", out_payload[PW-1:0], mk(41).pl);
        enq(2'b10, mk(0), mk(42), 1);
        check("slot1_only_valid", out_valid, 2'b11);
        check("slot1_only_pl", out_payload[2*PW-1:PW], mk(42).pl);
        drain(1);

        // Recall with count=5 while enqueue and dispatch are both active.
        enq(2'b11, mk(50), mk(51), 1);
        enq(2'b11, mk(52), mk(53), 1);
        enq(2'b01, mk(54), mk(0), 1);
        check("pre_recall_stall", in_stall, 1'b0);
        present(2'b11, mk(56), mk(57), 0);
        iq_ready  = 2'b11;
        if_recall = 1'b1;
        sb.delete();
        step();
        if_recall = 1'b0; in_valid = 2'b00; iq_ready = 2'b00;
        check("recall_valid", out_valid, 2'b00);
        check("recall_stall", in_stall, 1'b0);
        enq(2'b11, mk(60), mk(61), 1);
        check("post_recall_pl", out_payload[PW-1:0], mk(60).pl);
        check("post_recall_valid", out_valid, 2'b11);
        drain(1);

        // External flush empties the buffer too.
        enq(2'b11, mk(70), mk(71), 1);
        ext_flush = 1'b1;
        sb.delete();
        step();
        ext_flush = 1'b0;
        check("flush_valid", out_valid, 2'b00);
        step();
        check("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
